alu_arbiter: RTL and testbench

Round-robin arbiter that shares one `alu` instance among `NREQ` requesters. Each requester offers an operation (func, a, b) with a valid/ready handshake. The arbiter registers the winning operation onto the ALU's input side and tracks the owner through the ALU's one-cycle latency. It then returns the result on a shared response bus with a one-hot valid. It also drives the ALU reset and watches the ALU's `en_out` for lost results.

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle-latency ALU among NREQ requesters.
// Tracks result ownership through the ALU and flags issued operations whose result strobe never arrives.
module alu_arbiter #(
  parameter int DWIDTH = 16,
  parameter int NREQ   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [3*NREQ-1:0]      req_func,
  input  logic [DWIDTH*NREQ-1:0] req_a,
  input  logic [DWIDTH*NREQ-1:0] req_b,
  input  logic                   hold,
  output logic                   alu_rst_n,
  output logic                   alu_en_in,
  output logic [2:0]             alu_func,
  output logic [DWIDTH-1:0]      alu_a,
  output logic [DWIDTH-1:0]      alu_b,
  input  logic [DWIDTH-1:0]      alu_out,
  input  logic                   alu_en_out,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]      rsp_data,
  output logic                   busy,
  output logic                   err_lost
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NREQ - 1);

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return IDX_W'(sum);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [IDX_W-1:0]  ptr;
  logic              grant_any;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand;
  logic [2:0]        gnt_func;
  logic [DWIDTH-1:0] gnt_a;
  logic [DWIDTH-1:0] gnt_b;

  logic              tag_vld_p1;
  logic [IDX_W-1:0]  tag_idx_p1;
  logic              tag_vld_p2;
  logic [IDX_W-1:0]  tag_idx_p2;

  // Stage 0: combinational grant, search begins one past the last winner
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!rst && !hold) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = wrap_idx(ptr, k);
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  assign req_ready = grant_any ? onehot(grant_idx) : '0;

  always_comb begin
    gnt_func = '0;
    gnt_a    = '0;
    gnt_b    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        gnt_func = req_func[3*i +: 3];
        gnt_a    = req_a[DWIDTH*i +: DWIDTH];
        gnt_b    = req_b[DWIDTH*i +: DWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    alu_rst_n <= ~rst;
  end

  // Stage 1: issue register onto the ALU inputs, owner tag follows
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= PTR_RST;
      alu_en_in  <= 1'b0;
      alu_func   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      tag_vld_p1 <= 1'b0;
      tag_idx_p1 <= '0;
    end else begin
      alu_en_in  <= grant_any;
      tag_vld_p1 <= grant_any;
      if (grant_any) begin
        ptr        <= grant_idx;
        alu_func   <= gnt_func;
        alu_a      <= gnt_a;
        alu_b      <= gnt_b;
        tag_idx_p1 <= grant_idx;
      end
    end
  end

  // Stage 2: tag aligned with the ALU's internal result register
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_p2 <= 1'b0;
      tag_idx_p2 <= '0;
    end else begin
      tag_vld_p2 <= tag_vld_p1;
      tag_idx_p2 <= tag_idx_p1;
    end
  end

  // Stage 3: response register; a strobe without a live tag is dropped silently
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      err_lost  <= 1'b0;
    end else begin
      if (tag_vld_p2 && alu_en_out) begin
        rsp_valid <= onehot(tag_idx_p2);
        rsp_data  <= alu_out;
      end else begin
        rsp_valid <= '0;
      end
      if (tag_vld_p2 && !alu_en_out) err_lost <= 1'b1;
    end
  end

  assign busy = tag_vld_p1 | tag_vld_p2 | (|rsp_valid);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural one-cycle ALU attached.
// Function codes of the model: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, others return 0.
module tb_alu_arbiter;
  localparam int DW = 16;
  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           rst, hold;
  logic [NR-1:0]  req_valid, req_ready;
  logic [3*NR-1:0]  req_func;
  logic [DW*NR-1:0] req_a, req_b;
  logic           alu_rst_n, alu_en_in, alu_en_out;
  logic [2:0]     alu_func;
  logic [DW-1:0]  alu_a, alu_b, alu_out;
  logic [NR-1:0]  rsp_valid;
  logic [DW-1:0]  rsp_data;
  logic           busy, err_lost;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DWIDTH(DW), .NREQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_a(req_a), .req_b(req_b),
    .hold(hold),
    .alu_rst_n(alu_rst_n), .alu_en_in(alu_en_in), .alu_func(alu_func),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_en_out(alu_en_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .err_lost(err_lost)
  );

  // Behavioural ALU: registered result one cycle after en_in; kill_en swallows the strobe
  logic          alu_vld, kill_en;
  logic [DW-1:0] alu_res;

  function automatic logic [DW-1:0] alu_calc(input logic [2:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!alu_rst_n) begin
      alu_vld <= 1'b0;
      alu_res <= '0;
    end else begin
      alu_vld <= alu_en_in;
      if (alu_en_in) alu_res <= alu_calc(alu_func, alu_a, alu_b);
    end
  end

  assign alu_en_out = alu_vld & ~kill_en;
  assign alu_out    = alu_res;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [2:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_func[3*i +: 3] = f;
    req_a[DW*i +: DW]  = a;
    req_b[DW*i +: DW]  = b;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; kill_en = 1'b0;
    req_valid = '1; req_func = '0; req_a = '0; req_b = '0;
    step();
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want %b", req_ready, 4'b0000); end
    checks++; if (alu_en_in !== 1'b0) begin errors++; $display("FAIL reset_en_in: got %b want 0", alu_en_in); end
    checks++; if (alu_func !== 3'd0) begin errors++; $display("FAIL reset_func: got %h want 0", alu_func); end
    checks++; if (alu_a !== 16'h0 || alu_b !== 16'h0) begin errors++; $display("FAIL reset_operands: got %h/%h want 0/0", alu_a, alu_b); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
    checks++; if (busy !== 1'b0 || err_lost !== 1'b0) begin errors++; $display("FAIL reset_busy_err: got %b/%b want 0/0", busy, err_lost); end
    checks++; if (alu_rst_n !== 1'b0) begin errors++; $display("FAIL reset_alu_rst_n: got %b want 0", alu_rst_n); end
    rst = 1'b0; req_valid = '0;
    step();
    checks++; if (alu_rst_n !== 1'b1) begin errors++; $display("FAIL release_alu_rst_n: got %b want 1", alu_rst_n); end
  endtask

  task automatic test_single();
    set_op(2, 3'd0, 16'h0003, 16'h0004);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    checks++; if (alu_en_in !== 1'b1 || alu_func !== 3'd0) begin errors++; $display("FAIL single_issue: got en=%b func=%h want en=1 func=0", alu_en_in, alu_func); end
    checks++; if (alu_a !== 16'h0003 || alu_b !== 16'h0004) begin errors++; $display("FAIL single_operands: got %h/%h want 0003/0004", alu_a, alu_b); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    step();
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early_rsp: got %b want 0000", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 4'b0100 || rsp_data !== 16'h0007) begin errors++; $display("FAIL single_rsp: got %b/%h want 0100/0007", rsp_valid, rsp_data); end
    step();
    checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: got rsp=%b busy=%b want 0000/0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] ev [8];
    logic [DW-1:0] ed [8];
    int cnt [NR];
    int g;
    pulse_rst();
    for (int i = 0; i < NR; i++) cnt[i] = 0;
    for (int c = 0; c < 11; c++) begin
      if (c >= 3) begin
        checks++; if (rsp_valid !== ev[c-3] || rsp_data !== ed[c-3]) begin errors++; $display("FAIL rr_rsp%0d: got %b/%h want %b/%h", c-3, rsp_valid, rsp_data, ev[c-3], ed[c-3]); end
      end else begin
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rr_early_rsp%0d: got %b want 0000", c, rsp_valid); end
      end
      if (c < 8) begin
        for (int i = 0; i < NR; i++)
          set_op(i, 3'd0, 16'(16'h0100 * (i + 1) + cnt[i]), 16'(16'h0010 * (i + 1) + cnt[i]));
        req_valid = '1;
        #1;
        g = c % NR;
        ev[c] = 4'b0001 << g;
        ed[c] = 16'(16'h0110 * (g + 1) + 2 * cnt[g]);
        checks++; if (req_ready !== ev[c]) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", c, req_ready, ev[c]); end
        cnt[g]++;
      end else begin
        req_valid = '0;
      end
      step();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_pointer();
    logic [NR-1:0] seq [3];
    seq[0] = 4'b1000; seq[1] = 4'b0010; seq[2] = 4'b1000;
    pulse_rst();
    set_op(1, 3'd0, 16'h0001, 16'h0001);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL ptr_setup: got %b want 0010", req_ready); end
    step();
    set_op(3, 3'd2, 16'h00F0, 16'h0030);
    req_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (req_ready !== seq[c]) begin errors++; $display("FAIL ptr_alt%0d: got %b want %b", c, req_ready, seq[c]); end
      step();
    end
    set_op(0, 3'd0, 16'h00A0, 16'h000B);
    req_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL ptr_lone%0d: got %b want 0001", c, req_ready); end
      step();
    end
    req_valid = '0;
    step();
    step();
    checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 16'h00AB) begin errors++; $display("FAIL ptr_lone_rsp: got %b/%h want 0001/00ab", rsp_valid, rsp_data); end
    step();
    step();
  endtask

  task automatic test_hold();
    set_op(0, 3'd0, 16'h1000, 16'h0001);
    set_op(1, 3'd1, 16'h0050, 16'h0008);
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_grant0: got %b want 0010", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hold_grant1: got %b want 0001", req_ready); end
    step();
    for (int c = 2; c < 6; c++) begin
      hold = 1'b1;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hold_ready%0d: got %b want 0000", c, req_ready); end
      if (c == 3) begin
        checks++; if (rsp_valid !== 4'b0010 || rsp_data !== 16'h0048) begin errors++; $display("FAIL hold_rsp_a: got %b/%h want 0010/0048", rsp_valid, rsp_data); end
      end
      if (c == 4) begin
        checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 16'h1001 || busy !== 1'b1) begin errors++; $display("FAIL hold_rsp_b: got %b/%h busy=%b want 0001/1001 busy=1", rsp_valid, rsp_data, busy); end
      end
      if (c == 5) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_fall: got %b want 0", busy); end
      end
      step();
    end
    hold = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hold_resume: got %b want 0010", req_ready); end
    step();
    req_valid = '0;
    for (int c = 0; c < 4; c++) step();
  endtask

  task automatic test_lost();
    set_op(2, 3'd0, 16'h0005, 16'h0006);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL lost_grant: got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    step();
    kill_en = 1'b1;
    step();
    kill_en = 1'b0;
    checks++; if (rsp_valid !== 4'b0000 || err_lost !== 1'b1) begin errors++; $display("FAIL lost_flag: got rsp=%b err=%b want 0000/1", rsp_valid, err_lost); end
    step();
    step();
    checks++; if (err_lost !== 1'b1 || rsp_valid !== 4'b0000) begin errors++; $display("FAIL lost_sticky: got err=%b rsp=%b want 1/0000", err_lost, rsp_valid); end
    rst = 1'b1;
    step();
    checks++; if (err_lost !== 1'b0) begin errors++; $display("FAIL lost_clear: got %b want 0", err_lost); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    set_op(2, 3'd0, 16'h0009, 16'h0009);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_grant: got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    checks++; if (alu_en_in !== 1'b0 || alu_func !== 3'd0 || alu_a !== 16'h0 || alu_b !== 16'h0) begin errors++; $display("FAIL mid_issue_reset: got en=%b func=%h a=%h b=%h want 0", alu_en_in, alu_func, alu_a, alu_b); end
    checks++; if (rsp_valid !== 4'b0000 || rsp_data !== 16'h0 || busy !== 1'b0 || err_lost !== 1'b0) begin errors++; $display("FAIL mid_rsp_reset: got %b/%h busy=%b err=%b want 0", rsp_valid, rsp_data, busy, err_lost); end
    checks++; if (alu_rst_n !== 1'b0) begin errors++; $display("FAIL mid_alu_rst_low: got %b want 0", alu_rst_n); end
    rst = 1'b0;
    step();
    checks++; if (rsp_valid !== 4'b0000 || alu_rst_n !== 1'b1) begin errors++; $display("FAIL mid_after: got rsp=%b alu_rst_n=%b want 0000/1", rsp_valid, alu_rst_n); end
    for (int i = 0; i < NR; i++) set_op(i, 3'd4, 16'h00FF, 16'h0F0F);
    req_valid = '1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    step();
    step();
    checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 16'h0FF0) begin errors++; $display("FAIL mid_first_rsp: got %b/%h want 0001/0ff0", rsp_valid, rsp_data); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer();
    test_hold();
    test_lost();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
